// File: rtl/div_32x16_seq_if.sv
// rtl/div_32x16_seq_if.sv - operand/result handshake bundle for the sequential divider
// Purpose: groups the input (operand) and output (result) valid/ready channels.
// Signals:
//   in_valid  / in_ready   operand handshake (master -> slave / slave -> master)
//   dividend  [2*BIT]      unsigned dividend, master -> slave
//   divisor   [BIT]        unsigned divisor,  master -> slave
//   out_valid / out_ready  result handshake (slave -> master / master -> slave)
//   quotient, remainder    [BIT] results, slave -> master
//   dbz, ovf               divide-by-zero / quotient-overflow flags, slave -> master
interface div_32x16_seq_if #(
  parameter int BIT = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2*BIT-1:0] dividend;
  logic [BIT-1:0]   divisor;
  logic             out_valid;
  logic             out_ready;
  logic [BIT-1:0]   quotient;
  logic [BIT-1:0]   remainder;
  logic             dbz;
  logic             ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/div_32x16_seq.sv
// rtl/div_32x16_seq.sv - iterative restoring divider, 2*BIT / BIT, one quotient bit per clock
// Purpose: divides a 2*BIT-bit unsigned dividend by a BIT-bit unsigned divisor,
//   producing quotient, remainder and divide-by-zero / overflow flags.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-high
//   div_if   slave side of div_32x16_seq_if (operand and result valid/ready channels)
module div_32x16_seq #(
  parameter int BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  div_32x16_seq_if.slave div_if
);
  localparam int CW = $clog2(BIT);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [BIT-1:0]  r_q;      // partial remainder; stays below the divisor, so BIT bits suffice
  logic [BIT-1:0]  q_q;      // dividend low half shifting out, quotient bits shifting in
  logic [BIT-1:0]  dvs_q;
  logic [BIT-1:0]  quot_q;
  logic [BIT-1:0]  rem_q;
  logic            dbz_q;
  logic            ovf_q;

  logic [BIT:0]    t_d;
  logic [BIT:0]    diff_d;
  logic            ge_d;
  logic [BIT-1:0]  r_d;
  logic [BIT-1:0]  q_d;

  // One restoring step. Because R < divisor, T < 2*divisor, so the borrow bit
  // of T - divisor alone tells whether the subtraction fits.
  always_comb begin
    t_d    = {r_q, q_q[BIT-1]};
    diff_d = t_d - {1'b0, dvs_q};
    ge_d   = ~diff_d[BIT];
    r_d    = ge_d ? diff_d[BIT-1:0] : t_d[BIT-1:0];
    q_d    = {q_q[BIT-2:0], ge_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_if.in_valid) begin
            dvs_q <= div_if.divisor;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            if (div_if.divisor == '0) begin
              dbz_q   <= 1'b1;
              quot_q  <= '1;
              rem_q   <= div_if.dividend[BIT-1:0];
              state_q <= DONE;
            end else if (div_if.dividend[2*BIT-1:BIT] >= div_if.divisor) begin
              // High half already >= divisor: quotient needs more than BIT bits.
              ovf_q   <= 1'b1;
              quot_q  <= '1;
              rem_q   <= '0;
              state_q <= DONE;
            end else begin
              r_q     <= div_if.dividend[2*BIT-1:BIT];
              q_q     <= div_if.dividend[BIT-1:0];
              cnt_q   <= '0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIT - 1)) begin
            quot_q  <= q_d;
            rem_q   <= r_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (div_if.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_if.in_ready  = (state_q == IDLE);
  assign div_if.out_valid = (state_q == DONE);
  assign div_if.quotient  = quot_q;
  assign div_if.remainder = rem_q;
  assign div_if.dbz       = dbz_q;
  assign div_if.ovf       = ovf_q;
endmodule

// File: tb/tb_div_32x16_seq.sv
// tb/tb_div_32x16_seq.sv - randomized self-checking bench for div_32x16_seq
module tb_div_32x16_seq;
  logic clk;
  logic rst;
  int   tests;
  int   errors;

  div_32x16_seq_if #(.BIT(16)) bus ();

  div_32x16_seq #(.BIT(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {dbz, ovf, quotient, remainder} from plain arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [15:0] b);
    longint unsigned qq;
    longint unsigned rr;
    if (b == 16'd0) return {1'b1, 1'b0, 16'hFFFF, a[15:0]};
    qq = longint'(a) / longint'(b);
    rr = longint'(a) % longint'(b);
    if (qq > 64'd65535) return {1'b0, 1'b1, 16'hFFFF, 16'h0000};
    return {1'b0, 1'b0, qq[15:0], rr[15:0]};
  endfunction

  function automatic logic [33:0] observed();
    return {bus.dbz, bus.ovf, bus.quotient, bus.remainder};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int idle,
                        input int stall, input bit noise, input bit per_cycle, input string tag);
    logic [33:0] exp;
    int          lat;
    int          exp_lat;
    int          w;
    exp     = model(a, b);
    exp_lat = (exp[33] || exp[32]) ? 1 : 17;
    repeat (idle) @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check({tag, "_in_ready_timeout"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
    while (!bus.out_valid && lat < 200) begin
      if (noise) bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, 64'(observed()), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      if (noise) bus.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (per_cycle) begin
        check({tag, "_hold_valid_ready"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
        check({tag, "_hold_result"}, 64'(observed()), 64'(exp));
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_after_handshake"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    check({tag, "_result_kept"}, 64'(observed()), 64'(exp));
  endtask

  initial begin
    logic [15:0] b;
    logic [15:0] hi;
    logic [31:0] a;
    tests         = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    #12;
    check("reset_flags", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    check("reset_result", 64'(observed()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'hFFFE0001, 16'hFFFF, 0, 0, 1'b0, 1'b0, "max_exact");
    run_op(32'd1000,     16'd7,    0, 0, 1'b0, 1'b0, "d1000_7");
    run_op(32'h0000FFFF, 16'h0100, 1, 0, 1'b0, 1'b0, "ffff_100");
    run_op(32'h12345678, 16'h0000, 0, 0, 1'b0, 1'b0, "dbz");
    run_op(32'h00010000, 16'h0001, 0, 0, 1'b0, 1'b0, "ovf_eq");
    run_op(32'h00010000, 16'h0002, 0, 0, 1'b0, 1'b0, "half");
    run_op(32'd1000,     16'd7,    0, 10, 1'b1, 1'b1, "stall10");

    // Abort mid-CALC: after the accepting edge plus 8 CALC edges, count is 8.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 16'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_flags", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    check("abort_result", 64'(observed()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd1000, 16'd7, 0, 0, 1'b0, 1'b0, "after_abort");

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 5))
        0: begin b = 16'd0; a = $urandom; end
        1: begin b = 16'($urandom_range(1, 255)); a = $urandom; end
        2: begin
          b  = 16'($urandom_range(1, 65535));
          hi = 16'($urandom_range(0, int'(b) - 1));
          a  = {hi, 16'($urandom)};
        end
        3: begin
          b = 16'($urandom_range(1, 65535));
          a = {b, 16'($urandom)};
        end
        default: begin b = 16'($urandom); a = $urandom; end
      endcase
      run_op(a, b, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
